// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory access controller and its address decoder.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int WORD_W = 32;

  function automatic int word_offset(input int idx);
    return idx * WORD_W;
  endfunction

endpackage

// File: rtl/mem_addr_decoder.sv
// Combinational word-index decode: one-hot select plus an in-range flag.
module mem_addr_decoder #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  onehot,
  output logic              in_range
);

  always_comb begin
    onehot   = '0;
    // Extra MSB keeps the compare exact when DEPTH == 2**ADDR_W.
    in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/memory_access_ctrl.sv
// Request/response front-end for a bank of 32-bit memory words: one transaction
// at a time, registered one-hot write enables and a registered read response.
module memory_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [DEPTH-1:0]        word_en,
  output logic [DATA_W-1:0]       word_d,
  input  logic [DEPTH*DATA_W-1:0] word_q
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             r_state, w_nxt_state;
  logic [IDX_W-1:0]   r_idx, w_nxt_idx;
  logic               r_req_ready, w_nxt_req_ready;
  logic               r_rsp_valid, w_nxt_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata, w_nxt_rsp_rdata;
  logic               r_rsp_err, w_nxt_rsp_err;
  logic [DEPTH-1:0]   r_word_en, w_nxt_word_en;
  logic [DATA_W-1:0]  r_word_d, w_nxt_word_d;

  logic [DEPTH-1:0]   w_onehot;
  logic               w_in_range;
  logic [DATA_W-1:0]  w_words [DEPTH];

  mem_addr_decoder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr     (req_addr),
    .onehot   (w_onehot),
    .in_range (w_in_range)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_words
    assign w_words[g] = word_q[word_offset(g) +: WORD_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_word_en   <= '0;
      r_word_d    <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_idx       <= w_nxt_idx;
      r_req_ready <= w_nxt_req_ready;
      r_rsp_valid <= w_nxt_rsp_valid;
      r_rsp_rdata <= w_nxt_rsp_rdata;
      r_rsp_err   <= w_nxt_rsp_err;
      r_word_en   <= w_nxt_word_en;
      r_word_d    <= w_nxt_word_d;
    end
  end

  // Next-state and next-output values; every output is taken from a register.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_idx       = r_idx;
    w_nxt_req_ready = r_req_ready;
    w_nxt_rsp_valid = r_rsp_valid;
    w_nxt_rsp_rdata = r_rsp_rdata;
    w_nxt_rsp_err   = r_rsp_err;
    w_nxt_word_en   = '0;
    w_nxt_word_d    = r_word_d;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_nxt_idx       = req_addr[IDX_W-1:0];
          w_nxt_req_ready = 1'b0;
          if (!w_in_range) begin
            w_nxt_state     = RESP;
            w_nxt_rsp_valid = 1'b1;
            w_nxt_rsp_rdata = '0;
            w_nxt_rsp_err   = 1'b1;
          end else if (req_write) begin
            w_nxt_state   = WRITE;
            w_nxt_word_en = w_onehot;
            w_nxt_word_d  = req_wdata;
          end else begin
            w_nxt_state = READ;
          end
        end
      end
      WRITE: begin
        w_nxt_state     = RESP;
        w_nxt_rsp_valid = 1'b1;
        w_nxt_rsp_rdata = '0;
        w_nxt_rsp_err   = 1'b0;
      end
      READ: begin
        w_nxt_state     = RESP;
        w_nxt_rsp_valid = 1'b1;
        w_nxt_rsp_rdata = w_words[r_idx];
        w_nxt_rsp_err   = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          w_nxt_state     = IDLE;
          w_nxt_rsp_valid = 1'b0;
          w_nxt_rsp_rdata = '0;
          w_nxt_rsp_err   = 1'b0;
          w_nxt_req_ready = 1'b1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign word_en   = r_word_en;
  assign word_d    = r_word_d;

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Directed bench for memory_access_ctrl with a behavioural bank of eight 32-bit words.
module tb_memory_access_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_W-1:0]       req_addr;
  logic [DATA_W-1:0]       req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;
  logic [DEPTH-1:0]        word_en;
  logic [DATA_W-1:0]       word_d;
  logic [DEPTH*DATA_W-1:0] word_q;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  int n_pass  = 0;
  int n_total = 0;

  memory_access_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .word_en   (word_en),
    .word_d    (word_d),
    .word_q    (word_q)
  );

  always #5 clk = ~clk;

  // Word array: each word captures word_d on its enable.
  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (word_en[i]) mem[i] <= word_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_q
    assign word_q[g*DATA_W +: DATA_W] = mem[g];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("%s_word%0d", tag, i), mem[i], exp_mem[i]);
  endtask

  // Issues one request from a negedge; returns at a negedge. With rr=1 the
  // response is consumed and the controller is back in IDLE on return.
  task automatic txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd, input logic rr,
                     output logic [31:0] rd, output logic er, output logic [7:0] en_or,
                     output int en_cyc, output int lat);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    rsp_ready = rr;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_drop", {31'b0, req_ready}, 32'd0);
    en_or  = '0;
    en_cyc = 0;
    lat    = 1;
    while (!rsp_valid && lat < 10) begin
      if (word_en != '0) en_cyc++;
      en_or |= word_en;
      @(negedge clk);
      lat++;
    end
    if (word_en != '0) en_cyc++;
    en_or |= word_en;
    rd = rsp_rdata;
    er = rsp_err;
    if (rr) begin
      @(negedge clk);
      chk("rsp_valid_cleared", {31'b0, rsp_valid}, 32'd0);
      chk("rsp_rdata_cleared", rsp_rdata, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [7:0]  en_or;
    int          en_cyc;
    int          lat;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("rst_word_en",   {24'b0, word_en}, 32'd0);
    chk("rst_word_d",    word_d, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Write then read address 3.
    txn(1'b1, 8'd3, 32'hDEADBEEF, 1'b1, rd, er, en_or, en_cyc, lat);
    exp_mem[3] = 32'hDEADBEEF;
    chk("wr3_en_onehot", {24'b0, en_or}, 32'h08);
    chk("wr3_en_cycles", en_cyc, 32'd1);
    chk("wr3_latency",   lat, 32'd2);
    chk("wr3_err",       {31'b0, er}, 32'd0);
    chk("wr3_rdata",     rd, 32'd0);
    chk("wr3_word",      mem[3], 32'hDEADBEEF);
    chk("wr3_word_d_held", word_d, 32'hDEADBEEF);
    txn(1'b0, 8'd3, 32'h0, 1'b1, rd, er, en_or, en_cyc, lat);
    chk("rd3_rdata",   rd, 32'hDEADBEEF);
    chk("rd3_err",     {31'b0, er}, 32'd0);
    chk("rd3_no_en",   {24'b0, en_or}, 32'd0);
    chk("rd3_latency", lat, 32'd2);

    // Fill every word, then read all back.
    for (int i = 0; i < DEPTH; i++) begin
      txn(1'b1, 8'(i), 32'hA5A50000 + 32'(i), 1'b1, rd, er, en_or, en_cyc, lat);
      exp_mem[i] = 32'hA5A50000 + 32'(i);
      chk($sformatf("fill%0d_en", i), {24'b0, en_or}, 32'd1 << i);
      chk($sformatf("fill%0d_en_cycles", i), en_cyc, 32'd1);
    end
    check_bank("after_fill");
    for (int i = 0; i < DEPTH; i++) begin
      txn(1'b0, 8'(i), 32'h0, 1'b1, rd, er, en_or, en_cyc, lat);
      chk($sformatf("readback%0d", i), rd, exp_mem[i]);
    end

    // Out-of-range accesses.
    txn(1'b1, 8'd9, 32'hFFFFFFFF, 1'b1, rd, er, en_or, en_cyc, lat);
    chk("oor_wr_no_en", {24'b0, en_or}, 32'd0);
    chk("oor_wr_err",   {31'b0, er}, 32'd1);
    chk("oor_wr_rdata", rd, 32'd0);
    chk("oor_word_d_held", word_d, 32'hA5A50007);
    check_bank("after_oor");
    txn(1'b0, 8'd200, 32'h0, 1'b1, rd, er, en_or, en_cyc, lat);
    chk("oor_rd_err",   {31'b0, er}, 32'd1);
    chk("oor_rd_rdata", rd, 32'd0);
    txn(1'b0, 8'd1, 32'h0, 1'b1, rd, er, en_or, en_cyc, lat);
    chk("rd1_after_oor", rd, 32'hA5A50001);
    chk("rd1_err",       {31'b0, er}, 32'd0);

    // Backpressure on a read of address 0, with a request pulse in the window.
    txn(1'b0, 8'd0, 32'h0, 1'b0, rd, er, en_or, en_cyc, lat);
    chk("bp_first_rdata", rd, 32'hA5A50000);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_rsp_valid", k), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_rsp_rdata", k), rsp_rdata, 32'hA5A50000);
      chk($sformatf("bp%0d_req_ready", k), {31'b0, req_ready}, 32'd0);
      chk($sformatf("bp%0d_word_en", k),   {24'b0, word_en}, 32'd0);
      req_valid = (k == 1);
      req_write = 1'b1;
      req_addr  = 8'd5;
      req_wdata = 32'h12345678;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_no_late_txn", {31'b0, rsp_valid}, 32'd0);
    check_bank("after_bp");

    // Reset during the WRITE cycle.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'd2;
    req_wdata = 32'h0BAD0BAD;
    @(posedge clk);
    #2;
    chk("mid_wr_en_before_rst", {24'b0, word_en}, 32'h04);
    reset = 1'b1;
    #1;
    chk("mid_wr_rst_word_en",   {24'b0, word_en}, 32'd0);
    chk("mid_wr_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_wr_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid_wr_no_rsp%0d", k), {31'b0, rsp_valid}, 32'd0);
    end
    check_bank("after_mid_wr_reset");
    txn(1'b0, 8'd2, 32'h0, 1'b1, rd, er, en_or, en_cyc, lat);
    chk("rd2_old_value", rd, 32'hA5A50002);
    txn(1'b1, 8'd2, 32'hCAFEF00D, 1'b1, rd, er, en_or, en_cyc, lat);
    exp_mem[2] = 32'hCAFEF00D;
    chk("wr2_en", {24'b0, en_or}, 32'h04);
    chk("wr2_err", {31'b0, er}, 32'd0);
    txn(1'b0, 8'd2, 32'h0, 1'b1, rd, er, en_or, en_cyc, lat);
    chk("rd2_new_value", rd, 32'hCAFEF00D);
    check_bank("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
